// File: rtl/sm83_pkg.sv
// sm83_pkg: shared sequencer step, FSM state and datapath control types
package sm83_pkg;
  typedef enum logic [2:0] {
    STEP_READ_IMM   = 3'd0,
    STEP_READ_IND   = 3'd1,
    STEP_WRITE_IND  = 3'd2,
    STEP_INTERNAL   = 3'd3,
    STEP_EXEC_FETCH = 3'd4
  } seq_step_t;
  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} seq_state_t;
  typedef enum logic [1:0] {DB_NONE, DB_REG, DB_ALU, DB_Z} s_db_t;
  typedef enum logic [1:0] {AB_PC, AB_SP, AB_PAIR, AB_WZ} s_ab_t;
  typedef enum logic [1:0] {IDU_NOP, IDU_INC, IDU_DEC} idu_op_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR, ALU_CP,
    ALU_INC, ALU_DEC, ALU_RLC, ALU_RRC, ALU_PASS
  } alu_op_t;
  function automatic seq_step_t step_decode(input logic [2:0] raw);
    return raw > 3'd4 ? STEP_INTERNAL : seq_step_t'(raw);
  endfunction
endpackage

// File: rtl/sm83_tcycle_ctr.sv
// sm83_tcycle_ctr: T-state counter with memory wait states and bus timeout
module sm83_tcycle_ctr #(
  parameter int T_PER_M = 4,
  parameter int MAX_WAIT = 0,
  localparam int TW = $clog2(T_PER_M),
  localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          bus,
  input  logic          mem_ready,
  output logic [TW-1:0] t_state,
  output logic          m_done,
  output logic          timeout
);
  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);
  logic [TW-1:0] t_q, t_d;
  logic [WW-1:0] wait_q, wait_d;
  logic at_end;
  // last T-state stretches while the bus is not ready; a full wait count forces completion
  always_comb begin
    at_end = t_q == T_LAST;
    timeout = en && bus && at_end && !mem_ready && MAX_WAIT > 0 && wait_q == W_MAX;
    m_done = en && at_end && (!bus || mem_ready || timeout);
    t_d = !en || m_done ? '0 : at_end ? t_q : t_q + TW'(1);
    wait_d = !en || m_done ? '0 : at_end && wait_q != '1 ? wait_q + WW'(1) : wait_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q <= '0;
      wait_q <= '0;
    end else begin
      t_q <= t_d;
      wait_q <= wait_d;
    end
  end
  assign t_state = t_q;
endmodule

// File: rtl/sm83_mcycle_seq.sv
// sm83_mcycle_seq: registered M-cycle/T-state sequencer owning IR, Z and W
module sm83_mcycle_seq
  import sm83_pkg::*;
#(
  parameter int T_PER_M = 4,
  parameter int MAX_M = 6,
  parameter int MAX_WAIT = 0,
  parameter int DATA_W = 8,
  localparam int MIW = $clog2(MAX_M),
  localparam int TW = $clog2(T_PER_M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        step_kind,
  input  logic              step_dst,
  input  logic              step_last,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] d_in,
  output logic [MIW-1:0]    m_idx,
  output logic [TW-1:0]     t_state,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              addr_is_pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] z,
  output logic [DATA_W-1:0] w,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              exec_commit,
  output logic              bus_err,
  output logic              seq_err
);
  localparam logic [MIW-1:0] M_LAST = MIW'(MAX_M - 1);
  seq_state_t st_q, st_d;
  seq_step_t kind_q, kind_d, k;
  logic dst_q, dst_d, last_q, last_d, ovf_q, ovf_d, boot_q, boot_d;
  logic run, t0, cap, ovf_now, bus, done, m_done, timeout;
  logic [MIW-1:0] m_idx_q, m_idx_d;
  logic [DATA_W-1:0] ir_q, ir_d, z_q, z_d, w_q, w_d, data;
  sm83_tcycle_ctr #(.T_PER_M(T_PER_M), .MAX_WAIT(MAX_WAIT)) u_tctr (
    .clk(clk),
    .rst(rst),
    .en(run),
    .bus(bus),
    .mem_ready(mem_ready),
    .t_state(t_state),
    .m_done(m_done),
    .timeout(timeout)
  );
  // effective step: live decoder input at t_state 0 (boot fetch and overflow forced), held copy after
  always_comb begin
    run = st_q == S_RUN && !rst;
    t0 = t_state == '0;
    cap = run && t0;
    ovf_now = !boot_q && m_idx_q == M_LAST && !step_last;
    k = !t0 ? kind_q : boot_q || ovf_now ? STEP_EXEC_FETCH : step_decode(step_kind);
    bus = k != STEP_INTERNAL;
    mem_rd = run && (k == STEP_READ_IMM || k == STEP_READ_IND || k == STEP_EXEC_FETCH);
    mem_wr = run && k == STEP_WRITE_IND;
    addr_is_pc = run && (k == STEP_READ_IMM || k == STEP_EXEC_FETCH);
  end
  // FSM next state, held step fields, IR/Z/W loads, M-cycle index and completion strobes
  always_comb begin
    done = run && m_done;
    data = timeout ? '1 : d_in;
    st_d = S_RUN;
    boot_d = st_q == S_BOOT ? 1'b1 : done ? 1'b0 : boot_q;
    kind_d = cap ? k : kind_q;
    dst_d = cap ? step_dst : dst_q;
    last_d = cap ? step_last : last_q;
    ovf_d = cap ? ovf_now : ovf_q;
    z_d = done && (k == STEP_READ_IMM || k == STEP_READ_IND) && !dst_q ? data : z_q;
    w_d = done && (k == STEP_READ_IMM || k == STEP_READ_IND) && dst_q ? data : w_q;
    ir_d = done && k == STEP_EXEC_FETCH ? data : ir_q;
    m_idx_d = !done ? m_idx_q : k == STEP_EXEC_FETCH || last_q ? '0 : m_idx_q + MIW'(1);
    ir_load = done && k == STEP_EXEC_FETCH;
    exec_commit = done && k == STEP_EXEC_FETCH;
    pc_inc = done && (k == STEP_READ_IMM || k == STEP_EXEC_FETCH);
    bus_err = done && timeout;
    seq_err = done && ovf_q;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_BOOT;
      boot_q <= 1'b0;
      kind_q <= STEP_INTERNAL;
      dst_q <= 1'b0;
      last_q <= 1'b0;
      ovf_q <= 1'b0;
      m_idx_q <= '0;
      ir_q <= '0;
      z_q <= '0;
      w_q <= '0;
    end else begin
      st_q <= st_d;
      boot_q <= boot_d;
      kind_q <= kind_d;
      dst_q <= dst_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
      m_idx_q <= m_idx_d;
      ir_q <= ir_d;
      z_q <= z_d;
      w_q <= w_d;
    end
  end
  assign m_idx = m_idx_q;
  assign ir = ir_q;
  assign z = z_q;
  assign w = w_q;
endmodule

// File: tb/tb_sm83_mcycle_seq.sv
// tb_sm83_mcycle_seq: randomized M-cycle sequencer bench against a transaction-level model
module tb_sm83_mcycle_seq;
  localparam int T = 4, MM = 6, MW = 3;
  localparam int MIW = $clog2(MM), TW = $clog2(T);
  logic clk = 0, rst = 1;
  logic [2:0] step_kind = 0;
  logic step_dst = 0, step_last = 0, mem_ready = 0;
  logic [7:0] d_in = 0;
  logic [MIW-1:0] m_idx;
  logic [TW-1:0] t_state;
  logic mem_rd, mem_wr, addr_is_pc, ir_load, pc_inc, exec_commit, bus_err, seq_err;
  logic [7:0] ir, z, w;
  always #5 clk = ~clk;
  sm83_mcycle_seq #(.T_PER_M(T), .MAX_M(MM), .MAX_WAIT(MW), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .step_kind(step_kind), .step_dst(step_dst), .step_last(step_last),
    .mem_ready(mem_ready), .d_in(d_in), .m_idx(m_idx), .t_state(t_state), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .addr_is_pc(addr_is_pc), .ir(ir), .z(z), .w(w), .ir_load(ir_load),
    .pc_inc(pc_inc), .exec_commit(exec_commit), .bus_err(bus_err), .seq_err(seq_err)
  );
  logic [MIW-1:0] e_midx;
  logic [TW-1:0] e_t;
  logic e_rd, e_wr, e_pc, e_irl, e_pci, e_ex, e_be, e_se;
  logic [7:0] e_ir, e_z, e_w;
  logic chk_en = 0;
  int checks = 0, passes = 0, cyc = 0;
  int n_pci = 0, n_irl = 0, n_be = 0, n_se = 0;
  int m_idx_m = 0;
  logic [7:0] ir_m = 0, z_m = 0, w_m = 0;
  bit boot_m = 0;
  always @(posedge clk) cyc++;
  // every-cycle comparison of all outputs against the model's expectation
  always @(negedge clk) if (chk_en) begin
    checks++;
    if ({m_idx, t_state, mem_rd, mem_wr, addr_is_pc, ir_load, pc_inc, exec_commit, bus_err, seq_err, ir, z, w} ===
        {e_midx, e_t, e_rd, e_wr, e_pc, e_irl, e_pci, e_ex, e_be, e_se, e_ir, e_z, e_w})
      passes++;
    else
      $display("FAIL cycle %0d: m_idx %0d want %0d, t %0d want %0d, rd/wr/pc %b%b%b want %b%b%b, irl/pci/ex/be/se %b%b%b%b%b want %b%b%b%b%b, ir %h want %h, z %h want %h, w %h want %h",
               cyc, m_idx, e_midx, t_state, e_t, mem_rd, mem_wr, addr_is_pc, e_rd, e_wr, e_pc,
               ir_load, pc_inc, exec_commit, bus_err, seq_err, e_irl, e_pci, e_ex, e_be, e_se,
               ir, e_ir, z, e_z, w, e_w);
    n_pci += int'(pc_inc);
    n_irl += int'(ir_load);
    n_be += int'(bus_err);
    n_se += int'(seq_err);
  end
  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic rand_inputs();
    step_kind = 3'($urandom);
    step_dst = 1'($urandom);
    step_last = 1'($urandom);
    mem_ready = 1'($urandom);
    d_in = 8'($urandom);
  endtask
  task automatic zero_exp();
    m_idx_m = 0; ir_m = 0; z_m = 0; w_m = 0;
    {e_midx, e_t, e_rd, e_wr, e_pc, e_irl, e_pci, e_ex, e_be, e_se, e_ir, e_z, e_w} = '0;
  endtask
  task automatic boot();
    rst = 0;
    rand_inputs();
    zero_exp();
    chk_en = 1;
    @(posedge clk); #1;
    boot_m = 1;
  endtask
  task automatic mcycle(input int kind, input bit dst, input bit last, input int nwait,
                        input logic [7:0] data, input int rst_at);
    int ek, dur;
    bit ovf, bus, to, fin;
    logic [7:0] val;
    ovf = !boot_m && m_idx_m == MM - 1 && !last;
    ek = (boot_m || ovf) ? 4 : (kind > 4 ? 3 : kind);
    bus = ek != 3;
    to = bus && MW > 0 && nwait > MW;
    dur = T + (bus ? (to ? MW : nwait) : 0);
    val = to ? 8'hFF : data;
    for (int c = 0; c < dur; c++) begin
      fin = c == dur - 1;
      rand_inputs();
      if (c == 0) begin step_kind = 3'(kind); step_dst = dst; step_last = last; end
      if (bus && c >= T - 1) mem_ready = (c - (T - 1)) >= nwait;
      if (fin) d_in = data;
      rst = c == rst_at;
      e_midx = MIW'(m_idx_m); e_ir = ir_m; e_z = z_m; e_w = w_m;
      e_t = TW'(c < T ? c : T - 1);
      e_rd = !rst && (ek == 0 || ek == 1 || ek == 4);
      e_wr = !rst && ek == 2;
      e_pc = !rst && (ek == 0 || ek == 4);
      e_irl = !rst && fin && ek == 4;
      e_ex = e_irl;
      e_pci = !rst && fin && (ek == 0 || ek == 4);
      e_be = !rst && fin && to;
      e_se = !rst && fin && ovf;
      chk_en = 1;
      @(posedge clk); #1;
      if (rst) begin
        boot_m = 0;
        boot();
        return;
      end
    end
    if (ek == 0 || ek == 1) begin
      if (dst) w_m = val; else z_m = val;
    end
    if (ek == 4) ir_m = val;
    m_idx_m = (ek == 4 || last) ? 0 : m_idx_m + 1;
    boot_m = 0;
  endtask
  initial begin
    int c0, p0, b0, s0, i0;
    rand_inputs();
    rst = 1;
    @(posedge clk); #1;
    zero_exp();
    chk_en = 1;
    @(posedge clk); #1;
    boot();
    mcycle(int'($urandom_range(0, 7)), 1'b0, 1'b0, 0, 8'h00, -1);
    lit("boot_ir_load", n_irl, 1);
    lit("boot_pc_inc", n_pci, 1);
    for (int i = 0; i < 3; i++) mcycle(4, 1'b0, 1'b1, 0, 8'h3E, -1);
    lit("nop_ir", int'(ir), 'h3E);
    lit("nop_ir_model", int'(ir_m), 'h3E);
    lit("nop_exec_count", n_irl, 4);
    lit("nop_m_idx", int'(m_idx), 0);
    c0 = cyc; p0 = n_pci;
    mcycle(0, 1'b0, 1'b0, 0, 8'h42, -1);
    lit("ld_z", int'(z), 'h42);
    lit("ld_z_model", int'(z_m), 'h42);
    lit("ld_m_idx_mid", int'(m_idx), 1);
    mcycle(4, 1'b0, 1'b1, 0, 8'h00, -1);
    lit("ld_clocks", cyc - c0, 8);
    lit("ld_pc_incs", n_pci - p0, 2);
    lit("ld_m_idx_end", int'(m_idx), 0);
    c0 = cyc;
    mcycle(1, 1'b0, 1'b0, 3, 8'h5A, -1);
    lit("wait_clocks", cyc - c0, 7);
    lit("wait_z", int'(z), 'h5A);
    mcycle(4, 1'b0, 1'b1, 0, 8'h00, -1);
    b0 = n_be; c0 = cyc;
    mcycle(1, 1'b1, 1'b0, 10, 8'h12, -1);
    lit("timeout_clocks", cyc - c0, T + MW);
    lit("timeout_w", int'(w), 'hFF);
    lit("timeout_w_model", int'(w_m), 'hFF);
    mcycle(2, 1'b0, 1'b0, 10, 8'h34, -1);
    lit("timeout_bus_errs", n_be - b0, 2);
    lit("timeout_z_kept", int'(z), 'h5A);
    mcycle(4, 1'b0, 1'b1, 0, 8'h00, -1);
    s0 = n_se; i0 = n_irl;
    for (int i = 0; i < MM; i++) mcycle(3, 1'b0, 1'b0, 0, 8'hC3, -1);
    lit("ovf_seq_err", n_se - s0, 1);
    lit("ovf_ir_load", n_irl - i0, 1);
    lit("ovf_ir", int'(ir), 'hC3);
    lit("ovf_m_idx", int'(m_idx), 0);
    mcycle(1, 1'b0, 1'b0, 0, 8'h77, 2);
    lit("rst_z", int'(z), 0);
    mcycle(0, 1'b0, 1'b0, 0, 8'h00, T - 1);
    mcycle(int'($urandom_range(0, 7)), 1'b1, 1'b0, 0, 8'h99, -1);
    lit("reboot_ir", int'(ir), 'h99);
    for (int i = 0; i < 400; i++)
      mcycle(int'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 6)) : 0, 8'($urandom),
             $urandom_range(0, 39) == 0 ? int'($urandom_range(0, T - 1)) : -1);
    chk_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
